mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised CPU memory stage that replaces the fixed single-cycle data-memory wrapper. It sits between the execute/memory pipeline register and a variable-latency data memory. It converts load/store requests into a req/ack transaction with byte enables, and formats load data with byte extraction and sign/zero extension. It stalls the pipeline until the access completes and flags misaligned accesses and memory timeouts.

## Interface
- DATA_W, 16, data width in bits; a multiple of 8, at least 16
- ADDR_W, 16, byte address width
- TIMEOUT, 15, maximum BUSY cycles without dmem_ack before abort; range 1..255
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mem_readM  in  1  load request
- mem_writeM  in  1  store request
- byteM  in  1  1 = byte access, 0 = full-word access
- unsignedM  in  1  1 = zero-extend byte load, 0 = sign-extend
- alu_resultM  in  ADDR_W  effective byte address
- write_dataM  in  DATA_W  store data; low byte is used for byte stores
- alu_resultMout  out  ADDR_W  combinational pass-through of alu_resultM
- rd_dataM  out  DATA_W  formatted load result, registered
- stallM  out  1  hold the upstream pipeline
- misalignM  out  1  misaligned access flag
- timeoutM  out  1  timeout flag, one-cycle pulse
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address (low LB bits zeroed)
- dmem_wdata  out  DATA_W  lane-replicated write data
- dmem_be  out  DATA_W/8  byte enables
- dmem_rdata  in  DATA_W  read data, valid with ack
- dmem_ack  in  1  single-cycle completion

## Operation
- LB = clog2(DATA_W/8). The byte lane is alu_resultM[LB-1:0].
- access = mem_readM | mem_writeM. If both are high, the access is a write.
- A word access is misaligned when the lane bits are nonzero. Byte accesses are never misaligned.
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE, aligned access:
  - Latch the address, write data, byte enables and we.
  - Latch the load format: byte, unsigned and lane.
  - Next state is BUSY.
- IDLE, misaligned access:
  - No request is issued and the state stays IDLE.
  - misalignM = 1 combinationally. stallM = 0.
  - rd_dataM is cleared to 0 at the next edge.
- BUSY:
  - dmem_req = 1 and a wait counter increments each cycle.
  - On dmem_ack: capture the formatted load data into rd_dataM (writes leave rd_dataM at 0), then go to DONE.
  - If the counter reaches TIMEOUT without ack: drop req, set rd_dataM = 0, pulse timeoutM in the DONE cycle, then go to DONE.
- DONE: lasts one cycle with stallM = 0, so the pipeline advances. Next state is IDLE.
- stallM = (IDLE & access & aligned) | BUSY.
- dmem_ack outside BUSY is ignored.
- Byte store:
  - dmem_wdata replicates write_dataM[7:0] across all lanes.
  - dmem_be is one-hot at the lane.
- Word store: dmem_be is all ones and dmem_wdata = write_dataM.
- Byte load: take byte `lane` of dmem_rdata, then sign- or zero-extend it to DATA_W.
- Word load: rd_dataM = dmem_rdata.
- Reset (reset = 0, asynchronous):
  - State goes to IDLE and the counter is cleared.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, rd_dataM and timeoutM are all 0.
  - stallM and misalignM are forced to 0 while reset is low.
  - A reset mid-BUSY drops dmem_req immediately, and the transaction is abandoned.

## Timing
- Cycle 0: IDLE sees the access, stallM = 1.
- Cycle 1: BUSY, dmem_req = 1.
- Minimum latency with ack in cycle 1: cycle 2 is DONE, rd_dataM is valid and stallM = 0. Total is 3 cycles, with 2 stalled.
- Each extra wait cycle adds one stall cycle.
- A timeout gives TIMEOUT BUSY cycles, then DONE with timeoutM = 1.
- All dmem_* outputs are registered. The memory samples req, addr, we, wdata and be while req = 1.
- Back-to-back accesses: the cycle after DONE is IDLE and begins the next access with no extra gap.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - DATA_W and ADDR_W defaults;
  - the LB width function;
  - the TIMEOUT counter width constant (8 bits).
- Sub-module mem_lane_fmt is combinational and holds store lane replication, byte-enable generation and load byte extract/extend.
- Top-level mem_access_stage holds the FSM, the latches and the wait counter.

## Test plan
- Word store to 0x0010 of 0xBEEF, ack on first BUSY cycle:
  - dmem_be = 2'b11 and dmem_wdata = 0xBEEF.
  - stallM is high for 2 cycles, then DONE.
- Byte load from 0x0011 of memory word 0x80FF (lane 1 = 0x80):
  - with unsignedM = 0, rd_dataM = 0xFF80;
  - with unsignedM = 1, rd_dataM = 0x0080.
- Byte store of 0x1234 to 0x0021: dmem_wdata = 0x3434, dmem_be = 2'b10, dmem_addr = 0x0020.
- Word load at 0x0003:
  - misalignM = 1 and stallM = 0;
  - dmem_req never rises and rd_dataM = 0.
- Timeout with ack held low and TIMEOUT = 4: 4 BUSY cycles, then DONE with timeoutM = 1 and rd_dataM = 0.
- Mid-BUSY reset: reset pulled low during the BUSY cycle of a load drops dmem_req in the same cycle, and the block returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the FSM state encoding, default widths and the byte-lane helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int CNT_W      = 8;

    // Number of address bits that select a byte within one data word.
    function automatic int laneBits(input int dataW);
        return (dataW / 8 > 1) ? $clog2(dataW / 8) : 1;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatting: store data replication, byte enables,
// and load byte extraction with sign/zero extension.
module mem_lane_fmt
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    localparam int LB    = laneBits(DATA_W),
    localparam int NB    = DATA_W / 8
) (
    input  logic              storeByte,
    input  logic [LB-1:0]     storeLane,
    input  logic [DATA_W-1:0] storeData,
    output logic [DATA_W-1:0] laneData,
    output logic [NB-1:0]     laneBe,
    input  logic              loadByte,
    input  logic              loadUnsigned,
    input  logic [LB-1:0]     loadLane,
    input  logic [DATA_W-1:0] rawData,
    output logic [DATA_W-1:0] loadData
);

    logic [7:0] byteVal;
    logic       extBit;

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        laneData = storeByte ? {NB{storeData[7:0]}} : storeData;
        laneBe   = storeByte ? (NB'(1) << storeLane) : '1;
        byteVal  = rawData[{loadLane, 3'b000} +: 8];
        extBit   = loadUnsigned ? 1'b0 : byteVal[7];
        loadData = loadByte ? {{(DATA_W-8){extBit}}, byteVal} : rawData;
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: turns load/store requests into a req/ack transaction
// against a variable-latency data memory, stalling until completion or timeout.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 15,
    localparam int LB     = laneBits(DATA_W),
    localparam int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_readM,
    input  logic              mem_writeM,
    input  logic              byteM,
    input  logic              unsignedM,
    input  logic [ADDR_W-1:0] alu_resultM,
    input  logic [DATA_W-1:0] write_dataM,
    output logic [ADDR_W-1:0] alu_resultMout,
    output logic [DATA_W-1:0] rd_dataM,
    output logic              stallM,
    output logic              misalignM,
    output logic              timeoutM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [NB-1:0]     dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    stateT              state, nextState;
    logic [CNT_W-1:0]   waitCnt;
    logic               fmtByte, fmtUnsigned;
    logic [LB-1:0]      fmtLane;
    logic [LB-1:0]      reqLane;
    logic               access, isAligned;
    logic               startReq, misalignIdle, ackSeen, timedOut;
    logic [DATA_W-1:0]  laneData, loadData;
    logic [NB-1:0]      laneBe;

    assign alu_resultMout = alu_resultM;
    assign reqLane        = alu_resultM[LB-1:0];

    mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
        .storeByte    (byteM),
        .storeLane    (reqLane),
        .storeData    (write_dataM),
        .laneData     (laneData),
        .laneBe       (laneBe),
        .loadByte     (fmtByte),
        .loadUnsigned (fmtUnsigned),
        .loadLane     (fmtLane),
        .rawData      (dmem_rdata),
        .loadData     (loadData)
    );

    always_comb begin
        access       = mem_readM | mem_writeM;
        isAligned    = byteM || (reqLane == '0);
        startReq     = (state == IDLE) && access && isAligned;
        misalignIdle = (state == IDLE) && access && !isAligned;
        ackSeen      = (state == BUSY) && dmem_ack;
        timedOut     = (state == BUSY) && !dmem_ack && (waitCnt == CNT_W'(TIMEOUT - 1));
        // Async reset clears state at once, but the request inputs may still be high.
        stallM       = reset && (startReq || (state == BUSY));
        misalignM    = reset && misalignIdle;

        nextState = state;
        case (state)
            IDLE:    if (startReq) nextState = BUSY;
            BUSY:    if (ackSeen || timedOut) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt     <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
            rd_dataM    <= '0;
            timeoutM    <= 1'b0;
            fmtByte     <= 1'b0;
            fmtUnsigned <= 1'b0;
            fmtLane     <= '0;
        end else begin
            timeoutM <= timedOut;

            if (startReq) begin
                waitCnt     <= '0;
                dmem_req    <= 1'b1;
                dmem_we     <= mem_writeM;
                dmem_addr   <= {alu_resultM[ADDR_W-1:LB], LB'(0)};
                dmem_wdata  <= laneData;
                dmem_be     <= laneBe;
                fmtByte     <= byteM;
                fmtUnsigned <= unsignedM;
                fmtLane     <= reqLane;
            end else if (state == BUSY) begin
                waitCnt <= waitCnt + 1'b1;
            end

            if (ackSeen || timedOut) dmem_req <= 1'b0;

            if (misalignIdle || timedOut) rd_dataM <= '0;
            else if (ackSeen)             rd_dataM <= dmem_we ? '0 : loadData;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (16-bit data, TIMEOUT = 4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_readM = 1'b0, mem_writeM = 1'b0, byteM = 1'b0, unsignedM = 1'b0;
    logic [15:0] alu_resultM = '0, write_dataM = '0;
    logic [15:0] alu_resultMout, rd_dataM;
    logic        stallM, misalignM, timeoutM;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic [1:0]  dmem_be;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    int nCompared = 0;
    int nMismatch = 0;

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_readM(mem_readM), .mem_writeM(mem_writeM), .byteM(byteM), .unsignedM(unsignedM),
        .alu_resultM(alu_resultM), .write_dataM(write_dataM),
        .alu_resultMout(alu_resultMout), .rd_dataM(rd_dataM),
        .stallM(stallM), .misalignM(misalignM), .timeoutM(timeoutM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "bench time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setReq(input logic rd, input logic wr, input logic byt, input logic uns,
                          input logic [15:0] addr, input logic [15:0] wdata);
        mem_readM   = rd;
        mem_writeM  = wr;
        byteM       = byt;
        unsignedM   = uns;
        alu_resultM = addr;
        write_dataM = wdata;
    endtask

    // One aligned access: IDLE -> BUSY (+waits) -> ack -> DONE, checking each phase.
    task automatic doAccess(input string tag, input logic rd, input logic wr, input logic byt,
                            input logic uns, input logic [15:0] addr, input logic [15:0] wdata,
                            input int waits, input logic [15:0] rdata,
                            input logic [15:0] expAddr, input logic [1:0] expBe,
                            input logic [15:0] expWdata, input logic [15:0] expRd);
        tick();
        setReq(rd, wr, byt, uns, addr, wdata);
        #1;
        check({tag, " idle stall"}, 32'(stallM), 32'd1);
        check({tag, " passthru"}, 32'(alu_resultMout), 32'(addr));
        tick();
        check({tag, " req"}, 32'(dmem_req), 32'd1);
        check({tag, " we"}, 32'(dmem_we), 32'(wr));
        check({tag, " addr"}, 32'(dmem_addr), 32'(expAddr));
        check({tag, " be"}, 32'(dmem_be), 32'(expBe));
        check({tag, " wdata"}, 32'(dmem_wdata), 32'(expWdata));
        check({tag, " busy stall"}, 32'(stallM), 32'd1);
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, " wait req"}, 32'(dmem_req), 32'd1);
            check({tag, " wait stall"}, 32'(stallM), 32'd1);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack = 1'b0;
        #1;
        check({tag, " done stall"}, 32'(stallM), 32'd0);
        check({tag, " done req"}, 32'(dmem_req), 32'd0);
        check({tag, " rd_data"}, 32'(rd_dataM), 32'(expRd));
        check({tag, " done timeout"}, 32'(timeoutM), 32'd0);
    endtask

    initial begin
        // Reset held low with an aligned load presented: outputs must stay quiet.
        setReq(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000);
        tick();
        #1;
        check("rst stall", 32'(stallM), 32'd0);
        check("rst misalign", 32'(misalignM), 32'd0);
        check("rst req", 32'(dmem_req), 32'd0);
        check("rst rd_data", 32'(rd_dataM), 32'd0);
        check("rst timeout", 32'(timeoutM), 32'd0);
        check("rst be", 32'(dmem_be), 32'd0);
        tick();
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;

        doAccess("wstore", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 0, 16'h0000,
                 16'h0010, 2'b11, 16'hBEEF, 16'h0000);
        doAccess("bstore", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h1234, 0, 16'h0000,
                 16'h0020, 2'b10, 16'h3434, 16'h0000);
        doAccess("bload_s", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1, 16'h80FF,
                 16'h0010, 2'b10, 16'h0000, 16'hFF80);
        doAccess("bload_u", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 0, 16'h80FF,
                 16'h0010, 2'b10, 16'h0000, 16'h0080);
        doAccess("bload_l0", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'h80FF,
                 16'h0040, 2'b01, 16'h0000, 16'hFFFF);

        // Timeout: ack never arrives, four BUSY cycles then DONE with the pulse.
        tick();
        setReq(1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        #1;
        check("tmo idle stall", 32'(stallM), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tmo busy req", 32'(dmem_req), 32'd1);
            check("tmo busy stall", 32'(stallM), 32'd1);
            check("tmo busy pulse", 32'(timeoutM), 32'd0);
        end
        tick();
        check("tmo done pulse", 32'(timeoutM), 32'd1);
        check("tmo done rd_data", 32'(rd_dataM), 32'd0);
        check("tmo done req", 32'(dmem_req), 32'd0);
        check("tmo done stall", 32'(stallM), 32'd0);
        tick();
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("tmo pulse end", 32'(timeoutM), 32'd0);

        doAccess("wload", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 0, 16'h1357,
                 16'h0002, 2'b11, 16'h0000, 16'h1357);

        // Misaligned word load; a stray ack in IDLE must be ignored.
        tick();
        setReq(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hFFFF;
        #1;
        check("mis flag", 32'(misalignM), 32'd1);
        check("mis stall", 32'(stallM), 32'd0);
        tick();
        check("mis req", 32'(dmem_req), 32'd0);
        check("mis rd_data", 32'(rd_dataM), 32'd0);
        check("mis flag hold", 32'(misalignM), 32'd1);
        tick();
        check("mis req later", 32'(dmem_req), 32'd0);
        check("mis stall later", 32'(stallM), 32'd0);
        dmem_ack = 1'b0;
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        doAccess("wload2", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 0, 16'hA5C3,
                 16'h0006, 2'b11, 16'h0000, 16'hA5C3);

        // Reset asserted mid-BUSY: request and all registered outputs drop at once.
        tick();
        setReq(1'b1, 1'b0, 1'b0, 1'b0, 16'h0008, 16'h0000);
        tick();
        check("mrst busy req", 32'(dmem_req), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mrst req", 32'(dmem_req), 32'd0);
        check("mrst stall", 32'(stallM), 32'd0);
        check("mrst rd_data", 32'(rd_dataM), 32'd0);
        check("mrst addr", 32'(dmem_addr), 32'd0);
        check("mrst misalign", 32'(misalignM), 32'd0);
        tick();
        setReq(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        tick();
        check("post rst req", 32'(dmem_req), 32'd0);
        check("post rst stall", 32'(stallM), 32'd0);

        doAccess("recover", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h1111, 0, 16'h0000,
                 16'h0030, 2'b11, 16'h1111, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
